// File: rtl/wb_trace_reader.sv
// Register-file write-back trace capture: filters processor writes into a FIFO
// that a consumer drains; an arm/disarm/halt FSM gates capture and counts overflow drops.
module wb_trace_reader #(
  parameter int DEPTH       = 8,
  parameter bit STOP_ON_OVF = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     arm_i,
  input  logic                     disarm_i,
  input  logic                     wr_en_i,
  input  logic [4:0]               wr_reg_i,
  input  logic [31:0]              wr_data_i,
  input  logic [11:0]              wr_pc_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [11:0]              trace_pc_o,
  output logic [4:0]               trace_reg_o,
  output logic [31:0]              trace_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               drops_o,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    HALTED = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      drops_q, drops_d;
  logic [48:0]     mem_q [DEPTH];
  logic [48:0]     head;

  logic capture, pop, full, push, drop;

  assign full    = (count_q == FULL_CNT);
  assign capture = (state_q == ARMED) && wr_en_i && (wr_reg_i != 5'd0);
  assign pop     = (count_q != '0) && trace_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    state_d  = state_q;
    drops_d  = drops_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (disarm_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, HALTED: begin
          if (arm_i) begin
            state_d = ARMED;
            drops_d = 8'd0;
          end
        end
        ARMED: begin
          if (drop && STOP_ON_OVF) state_d = HALTED;
        end
        default: state_d = IDLE;
      endcase
    end

    if (drop && (drops_q != 8'hFF)) drops_d = drops_q + 8'd1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {wr_pc_i, wr_reg_i, wr_data_i};
  end

  assign head          = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign trace_valid_o = (count_q != '0);
  assign trace_pc_o    = head[48:37];
  assign trace_reg_o   = head[36:32];
  assign trace_data_o  = head[31:0];
  assign count_o       = count_q;
  assign drops_o       = drops_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_wb_trace_reader.sv
// Scoreboard bench for wb_trace_reader: expected entries are queued as writes are
// issued and compared against the FIFO head at every pop handshake.
module tb_wb_trace_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, disarm = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] wr_pc = '0;
  logic        ready = 1'b0;
  logic        ready2 = 1'b0;

  logic        tv, tv2;
  logic [11:0] tpc, tpc2;
  logic [4:0]  treg, treg2;
  logic [31:0] tdata, tdata2;
  logic [3:0]  cnt, cnt2;
  logic [7:0]  drops, drops2;
  logic [1:0]  st, st2;

  int nvec = 0;
  int nerr = 0;
  logic [48:0] expq [$];

  always #5 clk = ~clk;

  wb_trace_reader #(.DEPTH(8), .STOP_ON_OVF(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .disarm_i(disarm),
    .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data), .wr_pc_i(wr_pc),
    .trace_valid_o(tv), .trace_ready_i(ready),
    .trace_pc_o(tpc), .trace_reg_o(treg), .trace_data_o(tdata),
    .count_o(cnt), .drops_o(drops), .state_o(st)
  );

  wb_trace_reader #(.DEPTH(8), .STOP_ON_OVF(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .disarm_i(disarm),
    .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data), .wr_pc_i(wr_pc),
    .trace_valid_o(tv2), .trace_ready_i(ready2),
    .trace_pc_o(tpc2), .trace_reg_o(treg2), .trace_data_o(tdata2),
    .count_o(cnt2), .drops_o(drops2), .state_o(st2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [11:0] pc,
                    input bit expect_cap);
    wr_en = 1'b1; wr_reg = r; wr_data = d; wr_pc = pc;
    if (expect_cap) expq.push_back({pc, r, d});
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: every handshake seen mid-cycle pops the head on the next edge.
  always @(negedge clk) begin
    if (rst_n && tv && ready) begin
      nvec++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL pop_unexpected: got pc=0x%0h reg=%0d data=0x%0h, expected no entry",
                 tpc, treg, tdata);
      end else begin
        logic [48:0] e;
        e = expq.pop_front();
        if ({tpc, treg, tdata} !== e) begin
          nerr++;
          $display("FAIL pop_entry: got pc=0x%0h reg=%0d data=0x%0h, expected pc=0x%0h reg=%0d data=0x%0h",
                   tpc, treg, tdata, e[48:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_state", 32'(st), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_valid", 32'(tv), 32'd0);
    check("rst_drops", 32'(drops), 32'd0);
    check("rst_data", tdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single capture, 1-cycle latency, immediate pop
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed", 32'(st), 32'd1);
    ready = 1'b1;
    wr(5'd5, 32'h0000_00AA, 12'h010, 1'b1);
    check("lat_valid", 32'(tv), 32'd1);
    check("lat_reg", 32'(treg), 32'd5);
    check("lat_data", tdata, 32'h0000_00AA);
    check("lat_pc", 32'(tpc), 32'h010);
    tick();
    check("lat_count0", 32'(cnt), 32'd0);

    // r0 writes ignored
    wr(5'd0, 32'hFFFF_FFFF, 12'h020, 1'b0);
    check("r0_valid", 32'(tv), 32'd0);
    check("r0_count", 32'(cnt), 32'd0);
    check("r0_drops", 32'(drops), 32'd0);

    // Overflow halts; drain order r1..r8
    ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      wr(5'(i), 32'h100 + 32'(i), 12'(i), i <= 8);
    check("ovf_count", 32'(cnt), 32'd8);
    check("ovf_drops", 32'(drops), 32'd1);
    check("ovf_state", 32'(st), 32'd2);
    check("ovf_head_stable", 32'(treg), 32'd1);
    ready = 1'b1;
    repeat (8) tick();
    check("drain_count", 32'(cnt), 32'd0);

    // Arm with simultaneous write: not captured, drops cleared
    ready = 1'b0;
    arm = 1'b1;
    wr(5'd7, 32'h777, 12'h070, 1'b0);
    arm = 1'b0;
    check("arm_wr_state", 32'(st), 32'd1);
    check("arm_wr_count", 32'(cnt), 32'd0);
    check("arm_clr_drops", 32'(drops), 32'd0);

    // Full FIFO with simultaneous pop and capture
    for (int i = 10; i <= 17; i++)
      wr(5'(i), 32'h200 + 32'(i), 12'h100 + 12'(i), 1'b1);
    check("full_count", 32'(cnt), 32'd8);
    ready = 1'b1;
    wr(5'd18, 32'h212, 12'h112, 1'b1);
    check("fullpop_count", 32'(cnt), 32'd8);
    check("fullpop_drops", 32'(drops), 32'd0);
    check("fullpop_state", 32'(st), 32'd1);
    repeat (8) tick();
    check("fullpop_drain", 32'(cnt), 32'd0);

    // Arm and disarm together: disarm wins; IDLE ignores writes
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    check("disarm_wins", 32'(st), 32'd0);
    wr(5'd3, 32'h333, 12'h030, 1'b0);
    check("idle_nocap", 32'(cnt), 32'd0);

    // Mid-cycle reset discards queued entries
    arm = 1'b1; tick(); arm = 1'b0;
    ready = 1'b0;
    for (int i = 1; i <= 3; i++)
      wr(5'(i), 32'h300 + 32'(i), 12'(i), 1'b0);
    check("pre_rst_count", 32'(cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(cnt), 32'd0);
    check("async_rst_valid", 32'(tv), 32'd0);
    check("async_rst_state", 32'(st), 32'd0);
    check("async_rst_data", tdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Long overflow: STOP_ON_OVF=0 keeps capturing and saturates drops
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 300; i++)
      wr(5'd1, 32'(i), 12'h3FF, i < 8);
    check("nostop_count", 32'(cnt2), 32'd8);
    check("nostop_drops", 32'(drops2), 32'd255);
    check("nostop_state", 32'(st2), 32'd1);
    check("stop_drops", 32'(drops), 32'd1);
    check("stop_state", 32'(st), 32'd2);
    ready = 1'b1;
    repeat (8) tick();
    check("final_count", 32'(cnt), 32'd0);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
